// File: rtl/seq_divider4_if.sv
// rtl/seq_divider4_if.sv - start/operand/result bundle for the sequential divider
interface seq_divider4_if #(
  parameter int W = 4
);
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         busy;
  logic         done;
  logic         div_zero;

  modport master (
    output start, x, y,
    input  q, r, busy, done, div_zero
  );

  modport slave (
    input  start, x, y,
    output q, r, busy, done, div_zero
  );
endinterface

// File: rtl/seq_divider4.sv
// rtl/seq_divider4.sv - unsigned restoring divider, one quotient bit per clock
module seq_divider4 #(
  parameter int W = 4
) (
  input  logic           clock,
  input  logic           reset,
  seq_divider4_if.slave  bus
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_n;
  logic [W:0]     a, a_n;          // partial remainder, one guard bit
  logic [W-1:0]   qr, qr_n;        // dividend shifting out / quotient shifting in
  logic [W-1:0]   b, b_n;          // captured divisor
  logic [CW-1:0]  count, count_n;
  logic [W-1:0]   q_reg, q_n;
  logic [W-1:0]   r_reg, r_n;
  logic           dz, dz_n;

  logic [W:0]     a_sh;
  logic [W:0]     t;

  // State and datapath registers; reset discards any in-flight division
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      a     <= '0;
      qr    <= '0;
      b     <= '0;
      count <= '0;
      q_reg <= '0;
      r_reg <= '0;
      dz    <= 1'b0;
    end else begin
      state <= state_n;
      a     <= a_n;
      qr    <= qr_n;
      b     <= b_n;
      count <= count_n;
      q_reg <= q_n;
      r_reg <= r_n;
      dz    <= dz_n;
    end
  end

  // Next state and shift-subtract step; results load only when a division ends
  always_comb begin
    state_n = state;
    a_n     = a;
    qr_n    = qr;
    b_n     = b;
    count_n = count;
    q_n     = q_reg;
    r_n     = r_reg;
    dz_n    = dz;
    a_sh    = {a[W-1:0], qr[W-1]};
    t       = a_sh - {1'b0, b};

    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.y != '0) begin
            a_n     = '0;
            qr_n    = bus.x;
            b_n     = bus.y;
            count_n = '0;
            dz_n    = 1'b0;
            state_n = RUN;
          end else begin
            // Divide by zero answers immediately without iterating
            q_n     = '1;
            r_n     = bus.x;
            dz_n    = 1'b1;
            state_n = DONE;
          end
        end
      end
      RUN: begin
        if (!t[W]) begin
          a_n  = t;
          qr_n = {qr[W-2:0], 1'b1};
        end else begin
          a_n  = a_sh;
          qr_n = {qr[W-2:0], 1'b0};
        end
        count_n = count + 1'b1;
        if (count == CW'(W - 1)) begin
          q_n     = qr_n;
          r_n     = a_n[W-1:0];
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.q        = q_reg;
  assign bus.r        = r_reg;
  assign bus.div_zero = dz;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);

endmodule

// File: tb/tb_seq_divider4.sv
// tb/tb_seq_divider4.sv - scoreboard bench for the sequential divider
module tb_seq_divider4;

  localparam int W = 4;

  typedef struct {
    int x;
    int y;
    int q;
    int r;
    int dz;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  seq_divider4_if #(.W(W)) bus ();

  seq_divider4 #(.W(W)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int x, input int y);
    exp_t e;
    e.x = x;
    e.y = y;
    if (y == 0) begin
      e.q  = (1 << W) - 1;
      e.r  = x;
      e.dz = 1;
    end else begin
      e.q  = x / y;
      e.r  = x % y;
      e.dz = 0;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        check($sformatf("q x=%0d y=%0d", e.x, e.y), int'(bus.q), e.q);
        check($sformatf("r x=%0d y=%0d", e.x, e.y), int'(bus.r), e.r);
        check($sformatf("div_zero x=%0d y=%0d", e.x, e.y), int'(bus.div_zero), e.dz);
        if (e.dz == 0)
          check($sformatf("invariant x=%0d y=%0d", e.x, e.y),
                int'((int'(bus.q) * e.y + int'(bus.r) == e.x) && (int'(bus.r) < e.y)), 1);
      end
    end
  end

  task automatic wait_done(output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        lat = k;
        return;
      end
    end
  endtask

  // Called at a negedge in an IDLE cycle; returns at the negedge of the following IDLE cycle
  task automatic run_div(input int x, input int y, input bit hold,
                         input int hx, input int hy, output int done_cyc);
    int lat;
    int bc;
    bus.start = 1'b1;
    bus.x = W'(x);
    bus.y = W'(y);
    sb.push_back(model(x, y));
    @(posedge clk);
    #1;
    if (hold) begin
      bus.x = W'(hx);
      bus.y = W'(hy);
    end else begin
      bus.start = 1'b0;
      bus.x = ~bus.x;
      bus.y = ~bus.y;
    end
    wait_done(lat, bc);
    done_cyc = cyc;
    check($sformatf("latency x=%0d y=%0d", x, y), lat, (y == 0) ? 1 : W + 1);
    check($sformatf("busy_cycles x=%0d y=%0d", x, y), bc, (y == 0) ? 1 : W + 1);
    bus.start = 1'b0;
    @(negedge clk);
    check("idle_busy", int'(bus.busy), 0);
    check("idle_done", int'(bus.done), 0);
  endtask

  initial begin
    int dc1;
    int dc2;
    bus.start = 1'b0;
    bus.x = '0;
    bus.y = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_q", int'(bus.q), 0);
    check("reset_r", int'(bus.r), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_div_zero", int'(bus.div_zero), 0);
    reset = 1'b0;
    @(negedge clk);

    run_div(13, 4, 1'b0, 0, 0, dc1);
    run_div(15, 1, 1'b0, 0, 0, dc1);
    run_div(3, 7, 1'b0, 0, 0, dc1);
    run_div(15, 15, 1'b0, 0, 0, dc1);

    // Start held high with new operands through RUN and DONE is ignored
    run_div(14, 3, 1'b1, 5, 5, dc1);
    run_div(5, 5, 1'b0, 0, 0, dc1);

    run_div(9, 0, 1'b0, 0, 0, dc1);

    // Reset during the second RUN cycle discards the division
    bus.start = 1'b1;
    bus.x = 4'd12;
    bus.y = 4'd5;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrun_reset_q", int'(bus.q), 0);
    check("midrun_reset_r", int'(bus.r), 0);
    check("midrun_reset_busy", int'(bus.busy), 0);
    check("midrun_reset_done", int'(bus.done), 0);
    check("midrun_reset_div_zero", int'(bus.div_zero), 0);
    repeat (8) @(negedge clk);
    run_div(12, 5, 1'b0, 0, 0, dc1);

    run_div(9, 0, 1'b0, 0, 0, dc1);
    run_div(8, 2, 1'b0, 0, 0, dc1);

    // Back-to-back: second start in the IDLE cycle right after done
    run_div(7, 2, 1'b0, 0, 0, dc1);
    run_div(11, 3, 1'b0, 0, 0, dc2);
    check("back_to_back_spacing", dc2 - dc1, W + 2);

    for (int xi = 0; xi < (1 << W); xi++)
      for (int yi = 0; yi < (1 << W); yi++)
        run_div(xi, yi, 1'b0, 0, 0, dc1);

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
